// File: rtl/sel_arb_pkg.sv
// Shared types and constants for the round-robin selector arbiter.
package sel_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sel_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import sel_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Scan from the farthest offset down so the nearest set bit is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin owner arbiter for the 4-way sel-indexed selector.
// Optional forced release after HOLD_MAX cycles when SEL_ARB_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nobody owns; arbitrate whenever any req is set
//   ST_GRANT | owner holds gnt/sel until done[sel], req[sel] low, or limit
//   ST_GAP   | one dead cycle after a release, sel held; then arbitrate
module sel_rr_arbiter
  import sel_arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               timeout
);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               timeout_d;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               owner_rel;
  logic               force_rel;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_rel = done[sel] | ~req[sel];

`ifdef SEL_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_MAX - 1);

  // Remaining grant cycles; zero marks the last cycle the owner may keep.
  logic [HOLD_CNT_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else if (state_d == ST_GRANT && state_q != ST_GRANT) begin
      hold_q <= HOLD_LAST;
    end else if (state_q == ST_GRANT && hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  assign force_rel = (state_q == ST_GRANT) && (hold_q == '0);
`else
  logic unused_hold_cfg;

  assign force_rel       = 1'b0;
  assign unused_hold_cfg = ^{HOLD_MAX, HOLD_CNT_W};
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt;
    sel_d     = sel;
    timeout_d = 1'b0;

    case (state_q)
      ST_GRANT: begin
        if (owner_rel || force_rel) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          ptr_d     = sel + SEL_W'(1);
          timeout_d = force_rel & ~owner_rel;
        end
      end
      default: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      sel       <= sel_d;
      sel_valid <= (state_d == ST_GRANT);
      busy      <= (state_d != ST_IDLE);
      timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Self-checking bench for sel_rr_arbiter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_sel_rr_arbiter;

  localparam int HOLD_MAX_TB = 4;
`ifdef SEL_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who owns, whether we sit in the dead cycle, rotation pointer.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;
  int m_sel   = 0;

  sel_rr_arbiter #(.HOLD_MAX(HOLD_MAX_TB)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit rel;
    bit forced;
    bit found;
    int w;
    if (reset) begin
      m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_hold = 0; m_to = 1'b0; m_sel = 0;
    end else if (m_owner >= 0) begin
      rel    = done[m_owner] || !req[m_owner];
      forced = TO_EN && (m_hold == HOLD_MAX_TB - 1) && !rel;
      if (rel || forced) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
        m_to    = forced;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end else begin
      m_gap = 1'b0;
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        w = (m_ptr + k) % 4;
        if (!found && req[w]) begin
          found   = 1'b1;
          m_owner = w;
          m_sel   = w;
          m_hold  = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; done = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; done = 4'b1111;
    step();
    step();
    n_cmp++;
    if ({gnt, sel, sel_valid, busy, timeout} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b sel=%0d v=%b busy=%b to=%b, want all 0",
               gnt, sel, sel_valid, busy, timeout);
    end
    reset = 1'b0; req = '0; done = 4'b1111;
    step();
    n_cmp++;
    if ({gnt, sel_valid, busy} !== 6'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got gnt=%b v=%b busy=%b, want 0", gnt, sel_valid, busy);
    end
    done = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || sel_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b sel=%0d v=%b busy=%b, want 0100 2 1 1",
               gnt, sel, sel_valid, busy);
    end
    done = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || sel !== 2'd2 || sel_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_gap: got gnt=%b sel=%0d v=%b busy=%b, want 0000 2 0 1",
               gnt, sel, sel_valid, busy);
    end
    done = '0; req = '0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || sel !== 2'd2) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b sel=%0d, want 0 2", busy, sel);
    end
  endtask

  task automatic test_rotation();
    int exp;
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      exp = k % 4;
      n_cmp++;
      if (gnt !== 4'(1 << exp) || sel !== 2'(exp) || sel_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rotation_grant%0d: got gnt=%b sel=%0d, want sel=%0d", k, gnt, sel, exp);
      end
      step();
      step();
      done = 4'(1 << exp);
      step();
      n_cmp++;
      if (gnt !== 4'b0 || sel_valid !== 1'b0 || busy !== 1'b1 || sel !== 2'(exp) || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL rotation_gap%0d: got gnt=%b v=%b busy=%b sel=%0d to=%b, want 0 0 1 %0d 0",
                 k, gnt, sel_valid, busy, sel, timeout, exp);
      end
      done = '0;
      step();
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_non_owner_done();
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0110; done = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0010 || sel !== 2'd1) begin
        n_bad++;
        $display("FAIL non_owner_done_c%0d: got gnt=%b sel=%0d, want 0010 1", c, gnt, sel);
      end
    end
    done = '0; req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_req_gap: got gnt=%b busy=%b to=%b, want 0 1 0", gnt, busy, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_req_next: got gnt=%b sel=%0d to=%b, want 0100 2 0", gnt, sel, timeout);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0100;
    step();
    done = 4'b0100;
    step();
    done = '0; req = 4'b1000;
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_bad++;
      $display("FAIL midreset_setup: got gnt=%b sel=%0d, want 1000 3", gnt, sel);
    end
    step();
    step();
    reset = 1'b1; req = 4'b1010;
    step();
    n_cmp++;
    if ({gnt, sel, sel_valid, busy, timeout} !== 9'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got gnt=%b sel=%0d v=%b busy=%b to=%b, want all 0",
               gnt, sel, sel_valid, busy, timeout);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0010 || sel !== 2'd1 || sel_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ptr: got gnt=%b sel=%0d v=%b, want 0010 1 1", gnt, sel, sel_valid);
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 4'b1100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_bad++;
      $display("FAIL hold_first: got gnt=%b sel=%0d, want 0100 2", gnt, sel);
    end
`ifdef SEL_ARB_TIMEOUT_EN
    for (int c = 2; c <= HOLD_MAX_TB; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got gnt=%b to=%b, want 0100 0", c, gnt, timeout);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0 || timeout !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_forced: got gnt=%b to=%b busy=%b, want 0 1 1", gnt, timeout, busy);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_next: got gnt=%b sel=%0d to=%b, want 1000 3 0", gnt, sel, timeout);
    end
`else
    for (int c = 2; c <= 100; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_unbounded%0d: got gnt=%b to=%b, want 0100 0", c, gnt, timeout);
      end
    end
`endif
    req = '0;
    step();
    step();
  endtask

  task automatic test_random();
    logic [3:0] eg;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        done[b] = ($urandom_range(0, 3) == 0);
      end
      step();
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      n_cmp++;
      if ({gnt, sel, sel_valid, busy, timeout} !==
          {eg, 2'(m_sel), (m_owner >= 0), (m_owner >= 0) || m_gap, m_to}) begin
        n_bad++;
        $display("FAIL random_c%0d: got gnt=%b sel=%0d v=%b busy=%b to=%b, want gnt=%b sel=%0d v=%b busy=%b to=%b",
                 c, gnt, sel, sel_valid, busy, timeout,
                 eg, m_sel, (m_owner >= 0), (m_owner >= 0) || m_gap, m_to);
      end
    end
    reset = 1'b0; req = '0; done = '0;
  endtask

  initial begin
    reset = 1'b1; req = '0; done = '0;
    test_reset();
    test_single();
    test_rotation();
    test_non_owner_done();
    test_reset_mid_grant();
    test_hold_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
